// File: rtl/wb_mailbox_fifo.sv
// Wishbone mailbox: host-to-fabric TX FIFO, fabric-to-host RX FIFO, status/level/control
// registers and an RX threshold interrupt. One side effect per strobe assertion.
module wb_mailbox_fifo #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'h0040
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  irq
);
  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] tx_mem [Depth];
  logic [DATA_WIDTH-1:0] rx_mem [Depth];
  logic [PtrW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q, tx_level, rx_level;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_ovf_q, rx_udf_q, irq_en_q, irq_q;
  logic [7:0] rx_thresh_q;

  logic sel, access, is_data, rd_access;
  logic tx_push, tx_pop, rx_push, rx_pop, tx_ovf_set, rx_udf_set;
  logic status_wr, ctrl_wr, tx_flush, rx_flush;
  logic [DATA_WIDTH-1:0] rd_data;

  assign tx_level = tx_wr_q - tx_rd_q;
  assign rx_level = rx_wr_q - rx_rd_q;
  assign tx_empty = (tx_level == '0);
  assign rx_empty = (rx_level == '0);
  assign tx_full  = (tx_level == PtrW'(Depth));
  assign rx_full  = (rx_level == PtrW'(Depth));

  assign tx_data  = tx_mem[tx_rd_q[DEPTH_LOG2-1:0]];
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign wb_ack_o = (state_q == StAck);
  assign irq      = irq_q;

  assign sel = wb_stb_i & wb_cyc_i &
               (wb_adr_i[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);

  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      StIdle: if (sel) begin
        access  = 1'b1;
        state_d = StAck;
      end
      StAck:  state_d = StWait;
      StWait: if (!wb_stb_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A full TX is judged before any same-cycle fabric pop, so the write is still dropped.
  assign is_data    = access & (wb_adr_i[1:0] == 2'd0);
  assign rd_access  = access & !wb_we_i;
  assign tx_push    = is_data & wb_we_i & !tx_full;
  assign tx_ovf_set = is_data & wb_we_i & tx_full;
  assign rx_pop     = is_data & !wb_we_i & !rx_empty;
  assign rx_udf_set = is_data & !wb_we_i & rx_empty;
  assign status_wr  = access & wb_we_i & (wb_adr_i[1:0] == 2'd1);
  assign ctrl_wr    = access & wb_we_i & (wb_adr_i[1:0] == 2'd3);
  assign tx_flush   = ctrl_wr & wb_dat_i[0];
  assign rx_flush   = ctrl_wr & wb_dat_i[1];
  assign tx_pop     = tx_valid & tx_ready;
  assign rx_push    = rx_valid & rx_ready;

  always_comb begin
    rd_data = '0;
    case (wb_adr_i[1:0])
      2'd0: rd_data = rx_empty ? '0 : rx_mem[rx_rd_q[DEPTH_LOG2-1:0]];
      2'd1: rd_data = DATA_WIDTH'({9'd0, irq_q, rx_udf_q, tx_ovf_q,
                                   rx_full, rx_empty, tx_full, tx_empty});
      2'd2: rd_data = DATA_WIDTH'({8'(rx_level), 8'(tx_level)});
      2'd3: rd_data = DATA_WIDTH'({rx_thresh_q, 5'd0, irq_en_q, 2'b00});
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[DEPTH_LOG2-1:0]] <= wb_dat_i;
    if (rx_push) rx_mem[rx_wr_q[DEPTH_LOG2-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      tx_ovf_q    <= 1'b0;
      rx_udf_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      rx_thresh_q <= '0;
      irq_q       <= 1'b0;
      wb_dat_o    <= '0;
    end else begin
      state_q <= state_d;
      // Flush wins over any same-cycle push or pop.
      if (tx_flush) begin
        tx_wr_q <= '0;
        tx_rd_q <= '0;
      end else begin
        if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
        if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      end
      if (rx_flush) begin
        rx_wr_q <= '0;
        rx_rd_q <= '0;
      end else begin
        if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
        if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      end
      if (status_wr && wb_dat_i[4]) tx_ovf_q <= 1'b0;
      if (status_wr && wb_dat_i[5]) rx_udf_q <= 1'b0;
      if (tx_ovf_set) tx_ovf_q <= 1'b1;
      if (rx_udf_set) rx_udf_q <= 1'b1;
      if (ctrl_wr) begin
        irq_en_q    <= wb_dat_i[2];
        rx_thresh_q <= wb_dat_i[15:8];
      end
      if (rd_access) wb_dat_o <= rd_data;
      irq_q <= irq_en_q & (rx_thresh_q != 8'd0) & (8'(rx_level) >= rx_thresh_q);
    end
  end
endmodule

// File: tb/tb_wb_mailbox_fifo.sv
// Scoreboard bench for wb_mailbox_fifo: queue-based reference model, directed scenarios,
// then randomized host/fabric traffic.
module tb_wb_mailbox_fifo;
  localparam int DEPTH = 16;
  localparam logic [15:0] BASE = 16'h0040;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o, tx_data, rx_data = '0;
  logic wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_ack_o;
  logic tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready, irq;

  always #5 clk = ~clk;

  wb_mailbox_fifo dut (
    .clk(clk), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  typedef struct {logic is_rd; logic [15:0] data; int cyc;} exp_t;
  exp_t exp_q[$];
  logic [15:0] m_tx[$], m_rx[$];
  logic m_ovf, m_udf, m_irq_en, m_irq;
  logic [7:0] m_thresh;
  logic [15:0] m_dat, last_rd;
  int cycle = 0, checks = 0, errors = 0, ack_cnt = 0;
  bit checking = 0, new_req = 0, rand_fabric = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: one step per clock edge, using the inputs the DUT samples at that edge.
  task automatic model_step();
    int txn, rxn;
    bit irq_n, tx_pop, rx_push, tx_push, rx_pop, tx_fl, rx_fl;
    logic [15:0] rd;
    if (reset) begin
      m_tx.delete(); m_rx.delete(); exp_q.delete();
      m_ovf = 0; m_udf = 0; m_irq_en = 0; m_irq = 0; m_thresh = 0; m_dat = 0;
      checking = 1;
      return;
    end
    txn = m_tx.size(); rxn = m_rx.size();
    irq_n = m_irq_en && m_thresh != 0 && rxn >= int'(m_thresh);
    tx_pop = txn > 0 && tx_ready;
    rx_push = rx_valid && rxn < DEPTH;
    tx_push = 0; rx_pop = 0; tx_fl = 0; rx_fl = 0; rd = '0;
    if (new_req) begin
      case (wb_adr_i[1:0])
        2'd0: begin
          rd = (rxn > 0) ? m_rx[0] : 16'h0000;
          if (wb_we_i) begin
            if (txn < DEPTH) tx_push = 1; else m_ovf = 1;
          end else begin
            if (rxn > 0) rx_pop = 1; else m_udf = 1;
          end
        end
        2'd1: begin
          rd = {9'd0, m_irq, m_udf, m_ovf, rxn == DEPTH, rxn == 0, txn == DEPTH, txn == 0};
          if (wb_we_i && wb_dat_i[4]) m_ovf = 0;
          if (wb_we_i && wb_dat_i[5]) m_udf = 0;
        end
        2'd2: rd = {8'(rxn), 8'(txn)};
        default: begin
          rd = {m_thresh, 5'd0, m_irq_en, 2'b00};
          if (wb_we_i) begin
            tx_fl = wb_dat_i[0]; rx_fl = wb_dat_i[1];
            m_irq_en = wb_dat_i[2]; m_thresh = wb_dat_i[15:8];
          end
        end
      endcase
      exp_q.push_back('{is_rd: !wb_we_i, data: rd, cyc: cycle});
      if (!wb_we_i) m_dat = rd;
    end
    if (tx_pop) void'(m_tx.pop_front());
    if (tx_push) m_tx.push_back(wb_dat_i);
    if (tx_fl) m_tx.delete();
    if (rx_pop) void'(m_rx.pop_front());
    if (rx_push) m_rx.push_back(rx_data);
    if (rx_fl) m_rx.delete();
    m_irq = irq_n;
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
    model_step();
  end

  // Monitor: pops the scoreboard on every ack and checks fabric-side outputs each cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (checking) begin
      if (wb_ack_o) begin
        ack_cnt++;
        last_rd = wb_dat_o;
        if (exp_q.size() == 0) check("unexpected_ack", 16'd1, 16'd0);
        else begin
          e = exp_q.pop_front();
          check("ack_cycle", 16'(cycle), 16'(e.cyc));
          if (e.is_rd) check("read_data", wb_dat_o, e.data);
        end
      end
      check("tx_valid", 16'(tx_valid), 16'(m_tx.size() != 0));
      if (m_tx.size() != 0) check("tx_data", tx_data, m_tx[0]);
      check("rx_ready", 16'(rx_ready), 16'(m_rx.size() < DEPTH));
      check("irq", 16'(irq), 16'(m_irq));
      check("dat_o_hold", wb_dat_o, m_dat);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_fabric) begin
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 1) == 0);
      rx_data  = 16'($urandom);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic host(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                      input int hold, input bit pop_first);
    wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    new_req = (adr[15:2] == BASE[15:2]);
    if (pop_first) tx_ready = 1;
    cyc();
    new_req = 0;
    if (pop_first) tx_ready = 0;
    for (int i = 1; i < hold; i++) begin
      wb_dat_i = 16'($urandom);
      wb_adr_i[1:0] = 2'($urandom);
      cyc();
    end
    wb_stb_i = 0; wb_cyc_i = 0;
    cyc(); cyc();
  endtask

  task automatic push_rx(input logic [15:0] d);
    rx_valid = 1; rx_data = d;
    cyc();
    rx_valid = 0;
  endtask

  initial begin
    int acks0;
    logic [15:0] dat, adr;
    repeat (3) cyc();
    reset = 0;
    check("rst_ack", 16'(wb_ack_o), 16'd0);
    check("rst_dat", wb_dat_o, 16'h0000);
    check("rst_irq", 16'(irq), 16'd0);
    check("rst_tx_valid", 16'(tx_valid), 16'd0);
    check("rst_rx_ready", 16'(rx_ready), 16'd1);

    // Long strobe: single push, single ack.
    acks0 = ack_cnt;
    host(1, BASE, 16'hA5A5, 6, 0);
    check("long_stb_acks", 16'(ack_cnt - acks0), 16'd1);
    check("long_stb_tx_data", tx_data, 16'hA5A5);
    host(0, BASE + 2, 0, 1, 0);
    check("long_stb_level", last_rd, 16'h0001);

    // Fill TX, overflow, clear sticky bit.
    push_rx(16'h7777);
    for (int i = 0; i < 15; i++) host(1, BASE, 16'(i + 1), 1, 0);
    host(1, BASE, 16'h1234, 2, 0);
    host(0, BASE + 1, 0, 1, 0);
    check("status_ovf", last_rd, 16'h0012);
    host(1, BASE + 1, 16'h0010, 1, 0);
    host(0, BASE + 1, 0, 1, 0);
    check("status_ovf_clr", last_rd, 16'h0002);

    // Flush TX while the fabric pops in the same cycle.
    host(1, BASE + 3, 16'h0003, 1, 0);
    for (int i = 0; i < 5; i++) host(1, BASE, 16'(16'h0100 + i), 1, 0);
    host(1, BASE + 3, 16'h0001, 1, 1);
    check("flush_tx_valid", 16'(tx_valid), 16'd0);
    host(0, BASE + 2, 0, 1, 0);
    check("flush_levels", last_rd, 16'h0000);

    // RX ordering and underflow.
    for (int i = 1; i <= 3; i++) push_rx(16'(i));
    for (int i = 1; i <= 3; i++) begin
      host(0, BASE, 0, 2, 0);
      check("rx_order", last_rd, 16'(i));
    end
    host(0, BASE, 0, 1, 0);
    check("rx_empty_read", last_rd, 16'h0000);
    host(0, BASE + 1, 0, 1, 0);
    check("rx_udf_bit", 16'(last_rd[5]), 16'd1);
    host(1, BASE + 1, 16'h0020, 1, 0);

    // Threshold interrupt.
    host(1, BASE + 3, 16'h0304, 1, 0);
    for (int i = 0; i < 3; i++) push_rx(16'(16'h0A00 + i));
    check("irq_not_yet", 16'(irq), 16'd0);
    cyc();
    check("irq_rise", 16'(irq), 16'd1);
    host(0, BASE, 0, 1, 0);
    check("irq_drop", 16'(irq), 16'd0);

    // Reset while acking.
    host(1, BASE + 3, 16'h0104, 1, 0);
    push_rx(16'h0055);
    cyc(); cyc();
    wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = 1; wb_adr_i = BASE; wb_dat_i = 16'hBEEF;
    new_req = 1;
    cyc();
    new_req = 0; reset = 1; wb_stb_i = 0; wb_cyc_i = 0;
    cyc();
    reset = 0;
    check("rst_ack_ack", 16'(wb_ack_o), 16'd0);
    check("rst_ack_tx", 16'(tx_valid), 16'd0);
    check("rst_ack_irq", 16'(irq), 16'd0);
    cyc();

    // Non-matching address never acks.
    acks0 = ack_cnt;
    host(1, BASE + 16'h0010, 16'h1111, 5, 0);
    check("nomatch_acks", 16'(ack_cnt - acks0), 16'd0);

    // Randomized traffic.
    rand_fabric = 1;
    for (int n = 0; n < 400; n++) begin
      adr = BASE | 16'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) adr = adr + 16'h0010;
      dat = 16'($urandom);
      if (adr[1:0] == 2'd3)
        dat = {5'd0, 3'($urandom), 5'd0, 1'($urandom),
               ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00};
      host(1'($urandom), adr, dat, $urandom_range(1, 4), 0);
    end
    rand_fabric = 0; tx_ready = 0; rx_valid = 0;
    repeat (5) cyc();
    check("pending_acks", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_mailbox_fifo.md
Name: wb_mailbox_fifo

Overview:
- Wishbone slave that sits directly downstream of the GPMC-to-Wishbone bridge.
- Gives the BeagleBone host a bidirectional mailbox into fabric logic:
  - TX FIFO: host to fabric.
  - RX FIFO: fabric to host.
- Provides status and level registers and a threshold interrupt.
- Tolerates the bridge's long, ack-independent strobes: exactly one side effect per strobe assertion.

Parameters:
- ADDR_WIDTH, 16, Wishbone address width.
- DATA_WIDTH, 16, Wishbone and FIFO data width.
- DEPTH_LOG2, 4, log2 of each FIFO depth; range 2..7.
- BASE_ADDR, 16'h0040, block base address; decode uses bits [ADDR_WIDTH-1:2].

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- wb_adr_i, input, ADDR_WIDTH, word address from bridge.
- wb_dat_i, input, DATA_WIDTH, write data.
- wb_dat_o, output, DATA_WIDTH, registered read data.
- wb_we_i, input, 1, 1 = write.
- wb_stb_i, input, 1, strobe.
- wb_cyc_i, input, 1, cycle.
- wb_ack_o, output, 1, one-cycle acknowledge.
- tx_data, output, DATA_WIDTH, TX FIFO head.
- tx_valid, output, 1, TX FIFO not empty.
- tx_ready, input, 1, fabric pops TX when tx_valid & tx_ready.
- rx_data, input, DATA_WIDTH, fabric data to host.
- rx_valid, input, 1, fabric push request.
- rx_ready, output, 1, RX FIFO not full.
- irq, output, 1, registered RX threshold interrupt.

Behaviour:
- Reset (clk edge with reset=1):
  - Outputs: wb_ack_o=0, wb_dat_o=0, irq=0; tx_valid=0, rx_ready=1.
  - State: FSM=IDLE, both FIFOs empty, sticky flags 0, threshold 0, irq_en 0.
  - Reset mid-access discards the access with no ack.
- Select: sel = wb_stb_i & wb_cyc_i & (wb_adr_i[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]). Register index is wb_adr_i[1:0].
- FSM states:
  - IDLE: sel in cycle N → perform access at the end of N → go to ACK.
  - ACK: wb_ack_o=1 for exactly cycle N+1; wb_dat_o valid from N+1 → go to WAIT.
  - WAIT: held until wb_stb_i=0, then return to IDLE.
- Strobe rules:
  - Address or data changes during ACK/WAIT are ignored.
  - No second side effect until the strobe drops.
  - wb_dat_o holds its value until the next read access.
  - Non-matching address: no ack, no side effect, FSM stays IDLE.
- Register 0, DATA:
  - Write pushes wb_dat_i to TX. If TX is full when sampled (cycle N), data is dropped and tx_overflow is set. A same-cycle fabric pop does not rescue the write.
  - Read pops RX and returns the head. If RX is empty, returns 16'h0000 and sets rx_underflow.
- Register 1, STATUS:
  - bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full.
  - bit4 tx_overflow (sticky), bit5 rx_underflow (sticky), bit6 irq; other bits 0.
  - Write 1 clears bits 4/5; other bits are unaffected.
- Register 2, LEVELS: [7:0] tx_level, [15:8] rx_level, zero-extended, range 0..2^DEPTH_LOG2. Writes are ignored but still acked.
- Register 3, CONTROL:
  - bit0 tx_flush, bit1 rx_flush: write-only, self-clearing, read as 0.
  - bit2 irq_en: R/W.
  - [15:8] rx_thresh: R/W.
- FIFOs:
  - Circular buffers, pointers DEPTH_LOG2+1 bits wide, wrap naturally.
  - full when level == 2^DEPTH_LOG2.
  - Simultaneous push and pop on a non-full, non-empty FIFO: both occur, level unchanged.
  - Push to an empty FIFO is visible on tx_valid / rx_empty the next cycle (no fall-through bypass).
- Fabric side:
  - tx_data = TX head; tx_valid = !tx_empty.
  - rx_ready = !rx_full; a push with rx_valid & !rx_ready is ignored by handshake.
- Flush wins over any same-cycle push or pop on that FIFO; level=0 next cycle.
- irq (registered, one cycle after the condition changes) = irq_en & (rx_thresh != 0) & (rx_level >= rx_thresh).

Test Plan:
- Write 0xA5A5 to BASE+0 with strobe held 6 cycles → one ack in cycle 2, tx_level=1, tx_valid=1, tx_data=0xA5A5; no second push.
- Push 16 words at DEPTH_LOG2=4, then write 0x1234 → STATUS reads 0x0012 (tx_full, tx_overflow). Write STATUS 0x0010 → reads 0x0002.
- Fabric pushes 0x0001..0x0003, host reads BASE+0 three times → 1,2,3 in order. Fourth read returns 0x0000 with rx_underflow=1.
- CONTROL=0x0304 (thresh 3, irq_en), fabric pushes 3 words → irq rises one cycle after the 3rd push; one host read drops irq.
- TX holds 5 words; write CONTROL bit0 while tx_ready=1 the same cycle → tx_level=0, tx_valid=0, no extra pop.
- Assert reset during ACK → ack=0 next cycle, FIFOs empty, irq=0. A strobe to BASE+0x10 (no decode match) never acks.
